logit_shift8: RTL and testbench

Pre-normalisation stage placed directly upstream of the 8-bit softmax. It takes a flat bus of NODES signed 8-bit logits from the final MLP layer, finds the maximum logit, and emits x[i] − max saturated to signed 8-bit. Every output is therefore ≤ 0, which keeps the softmax exponent table in its accurate negative range. It also reports the arg-max index and value for classification without running the softmax.

---
 rtl/logit_shift8_pkg.sv | 18 +
 rtl/logit_shift8_if.sv | 24 ++
 rtl/logit_shift8_sat_sub8.sv | 37 +++
 rtl/logit_shift8.sv | 113 +++++++++++
 tb/tb_logit_shift8.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/logit_shift8_pkg.sv
// Shared definitions for the logit pre-normalisation stage and its softmax/argmax consumers.
package logit_shift8_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_MAX,
      S_SHIFT
   } state_t;

   localparam logic signed [7:0] SAT_MIN = -8'sd128;
   localparam logic signed [7:0] SAT_MAX = 8'sd0;

   function automatic logic signed [8:0] sext9(input logic signed [7:0] v);
      return {v[7], v};
   endfunction

endpackage

// File: rtl/logit_shift8_if.sv
// Start/logit bus between the final MLP layer, logit_shift8 and the softmax.
interface logit_shift8_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NODES      = 387,
   parameter int IDX_WIDTH  = $clog2(NODES)
);
   logic                         start;
   logic [DATA_WIDTH*NODES-1:0]  inputs;
   logic [DATA_WIDTH*NODES-1:0]  outputs;
   logic signed [DATA_WIDTH-1:0] max_val;
   logic [IDX_WIDTH-1:0]         max_idx;
   logic                         busy;
   logic                         done;

   modport master (
      output start, inputs,
      input  outputs, max_val, max_idx, busy, done
   );

   modport slave (
      input  start, inputs,
      output outputs, max_val, max_idx, busy, done
   );
endinterface

// File: rtl/logit_shift8_sat_sub8.sv
// Combinational x - max, saturated to [-128, 0]; with LOGIT_SHIFT_TEMP_EN defined the
// result is also arithmetic-right-shifted by TEMP_SHIFT (temperature scaling).
module sat_sub8
   import logit_shift8_pkg::*;
`ifdef LOGIT_SHIFT_TEMP_EN
#(
   parameter int TEMP_SHIFT = 0
)
`endif
(
   input  logic signed [7:0] a,
   input  logic signed [7:0] b,
   output logic signed [7:0] y
);
   localparam logic signed [8:0] SAT_MIN_9 = {SAT_MIN[7], SAT_MIN};
   localparam logic signed [8:0] SAT_MAX_9 = {SAT_MAX[7], SAT_MAX};

   logic signed [8:0] diff;
   logic signed [7:0] sat;

   // The positive clamp never fires for a true maximum but keeps the output safe by construction.
   always_comb begin
      diff = sext9(a) - sext9(b);
      if (diff < SAT_MIN_9) begin
         sat = SAT_MIN;
      end else if (diff > SAT_MAX_9) begin
         sat = SAT_MAX;
      end else begin
         sat = diff[7:0];
      end
`ifdef LOGIT_SHIFT_TEMP_EN
      y = sat >>> TEMP_SHIFT;
`else
      y = sat;
`endif
   end
endmodule

// File: rtl/logit_shift8.sv
// Finds the max logit and arg-max, then emits x[i] - max saturated to int8 ahead of the softmax.
// Optional temperature scaling of the outputs is enabled by defining LOGIT_SHIFT_TEMP_EN.
module logit_shift8
   import logit_shift8_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NODES      = 387,
   parameter int IDX_WIDTH  = $clog2(NODES)
`ifdef LOGIT_SHIFT_TEMP_EN
   ,
   parameter int TEMP_SHIFT = 0
`endif
) (
   input  logic         clk,
   input  logic         reset,
   logit_shift8_if.slave bus
);
   state_t state, next_state;

   logic signed [DATA_WIDTH-1:0] data [NODES];
   logic signed [DATA_WIDTH-1:0] run_max;
   logic [IDX_WIDTH-1:0]         run_idx;
   logic [IDX_WIDTH-1:0]         idx;
   logic                         last;
   logic                         cand_gt;
   logic signed [DATA_WIDTH-1:0] shifted;

   assign last    = (idx == IDX_WIDTH'(NODES - 1));
   assign cand_gt = (data[idx] > run_max);

`ifdef LOGIT_SHIFT_TEMP_EN
   sat_sub8 #(.TEMP_SHIFT(TEMP_SHIFT)) u_sat (
      .a (data[idx]),
      .b (bus.max_val),
      .y (shifted)
   );
`else
   sat_sub8 u_sat (
      .a (data[idx]),
      .b (bus.max_val),
      .y (shifted)
   );
`endif

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (bus.start) next_state = S_LOAD;
         S_LOAD:  next_state = S_MAX;
         S_MAX:   if (last) next_state = S_SHIFT;
         S_SHIFT: if (last) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Snapshot of the logits so upstream is free to move on once the run has started.
   always_ff @(posedge clk) begin
      if (state == S_LOAD) begin
         for (int i = 0; i < NODES; i++) begin
            data[i] <= bus.inputs[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         idx          <= '0;
         run_max      <= '0;
         run_idx      <= '0;
         bus.outputs  <= '0;
         bus.max_val  <= '0;
         bus.max_idx  <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         state    <= next_state;
         bus.busy <= (next_state != S_IDLE);
         bus.done <= 1'b0;
         case (state)
            S_LOAD: begin
               run_max <= bus.inputs[DATA_WIDTH-1:0];
               run_idx <= '0;
               idx     <= IDX_WIDTH'(1);
            end
            // Strict compare keeps the lowest index on ties; the final element is folded into the commit.
            S_MAX: begin
               if (cand_gt) begin
                  run_max <= data[idx];
                  run_idx <= idx;
               end
               if (last) begin
                  bus.max_val <= cand_gt ? data[idx] : run_max;
                  bus.max_idx <= cand_gt ? idx : run_idx;
                  idx         <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_SHIFT: begin
               bus.outputs[idx*DATA_WIDTH +: DATA_WIDTH] <= shifted;
               if (last) begin
                  bus.done <= 1'b1;
                  idx      <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_logit_shift8.sv
// Directed and random runs of logit_shift8 (NODES=4) against a plain-arithmetic reference model.
module tb_logit_shift8;
   localparam int N  = 4;
   localparam int DW = 8;
`ifdef LOGIT_SHIFT_TEMP_EN
   localparam int TS = 1;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logit_shift8_if #(.DATA_WIDTH(DW), .NODES(N), .IDX_WIDTH(2)) bus ();

   logit_shift8 #(
      .DATA_WIDTH (DW),
      .NODES      (N),
      .IDX_WIDTH  (2)
`ifdef LOGIT_SHIFT_TEMP_EN
      ,
      .TEMP_SHIFT (TS)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int vec     [N];
   int exp_out [N];
   int exp_max;
   int exp_idx;

   task automatic check_output(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Reference: arg-max with lowest index on ties, clamped difference, optional floor-halving.
   task automatic compute_model();
      int d;
      exp_max = vec[0];
      exp_idx = 0;
      for (int i = 1; i < N; i++) begin
         if (vec[i] > exp_max) begin
            exp_max = vec[i];
            exp_idx = i;
         end
      end
      for (int i = 0; i < N; i++) begin
         d = vec[i] - exp_max;
         if (d < -128) d = -128;
`ifdef LOGIT_SHIFT_TEMP_EN
         d = d >>> TS;
`endif
         exp_out[i] = d;
      end
   endtask

   task automatic apply_stimulus(input bit hold);
      for (int i = 0; i < N; i++) bus.inputs[i*DW +: DW] = 8'(vec[i]);
      compute_model();
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
      for (int k = 1; k <= 2*N; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 1) bus.inputs = {$urandom};
         if (!hold && k == 2) bus.start = 1'b1;
         if (!hold && k == 3) bus.start = 1'b0;
         if (k < 2*N) begin
            check_output($sformatf("busy_k%0d", k), 32'(bus.busy), 1);
            check_output($sformatf("done_early_k%0d", k), 32'(bus.done), 0);
         end
         if (k == N) begin
            check_output("max_val", $signed(bus.max_val), exp_max);
            check_output("max_idx", 32'(bus.max_idx), exp_idx);
         end
         if (k == 2*N) begin
            check_output("done_pulse", 32'(bus.done), 1);
            check_output("busy_end", 32'(bus.busy), 0);
            for (int i = 0; i < N; i++) begin
               check_output($sformatf("out%0d", i), $signed(bus.outputs[i*DW +: DW]), exp_out[i]);
            end
         end
      end
      if (!hold) begin
         @(posedge clk);
         @(negedge clk);
         check_output("done_one_cycle", 32'(bus.done), 0);
         check_output("idle_after", 32'(bus.busy), 0);
      end
   endtask

   task automatic random_vec(input bit with_tie);
      for (int i = 0; i < N; i++) vec[i] = int'($urandom_range(0, 255)) - 128;
      if (with_tie) vec[$urandom_range(1, N-1)] = vec[0] > vec[1] ? vec[0] : vec[1];
   endtask

   initial begin
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.inputs = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("rst_outputs", 32'(bus.outputs), 0);
      check_output("rst_max_val", $signed(bus.max_val), 0);
      check_output("rst_max_idx", 32'(bus.max_idx), 0);
      check_output("rst_busy", 32'(bus.busy), 0);
      check_output("rst_done", 32'(bus.done), 0);
      reset = 1'b0;

      $display("[TB] directed vectors");
      vec = '{10, -3, 50, 7};
      apply_stimulus(1'b0);
      vec = '{127, -128, 0, 127};
      apply_stimulus(1'b0);
      vec = '{-5, -5, -5, -5};
      apply_stimulus(1'b0);
      vec = '{-128, 127, -128, 126};
      apply_stimulus(1'b0);

      $display("[TB] reset during SHIFT");
      vec = '{1, 2, 3, 4};
      for (int i = 0; i < N; i++) bus.inputs[i*DW +: DW] = 8'(vec[i]);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_output("midrst_outputs", 32'(bus.outputs), 0);
      check_output("midrst_max_val", $signed(bus.max_val), 0);
      check_output("midrst_max_idx", 32'(bus.max_idx), 0);
      check_output("midrst_busy", 32'(bus.busy), 0);
      check_output("midrst_done", 32'(bus.done), 0);
      reset = 1'b0;
      for (int k = 0; k < 2*N; k++) begin
         @(posedge clk);
         @(negedge clk);
         check_output($sformatf("postrst_done_k%0d", k), 32'(bus.done), 0);
         check_output($sformatf("postrst_busy_k%0d", k), 32'(bus.busy), 0);
      end
      vec = '{10, -3, 50, 7};
      apply_stimulus(1'b0);

      $display("[TB] back-to-back with start held high");
      vec = '{-20, 90, 90, -100};
      apply_stimulus(1'b1);
      random_vec(1'b0);
      apply_stimulus(1'b1);
      random_vec(1'b1);
      apply_stimulus(1'b1);
      bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_output("b2b_done_drop", 32'(bus.done), 0);
      check_output("b2b_idle", 32'(bus.busy), 0);

      $display("[TB] random vectors");
      for (int r = 0; r < 12; r++) begin
         random_vec(r[0]);
         apply_stimulus(1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
